// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared decode constants and FSM type for the PC sequencer
package pc_seq_pkg;

  localparam logic [2:0] CTRL_CLASS = 3'b111;

  localparam logic [1:0] OP_BR  = 2'b00;
  localparam logic [1:0] OP_JMP = 2'b01;
  localparam logic [1:0] OP_JSB = 2'b10;
  localparam logic [1:0] OP_RET = 2'b11;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - LIFO return-address stack; only the stack pointer is reset
module ret_stack #(
  parameter  int DEPTH = 8,
  parameter  int W     = 12,
  localparam int AW    = $clog2(DEPTH),
  localparam int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    wdata,
  output logic [W-1:0]    rdata,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;
  logic [SP_W-1:0] sp_m1;

  assign sp    = sp_q;
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - SP_W'(1);

  // Top of stack is visible combinationally so RET can retarget in the same cycle.
  assign rdata = mem_q[sp_m1[AW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[sp_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, control-flow decode, next-PC select and RUN/HALT FSM
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int PC_W        = 12,
  parameter  int STACK_DEPTH = 8,
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [18:0]     instruction,
  input  logic            pc_en,
  input  logic            c_flag,
  input  logic            z_flag,
  output logic [PC_W-1:0] pc,
  output logic            push,
  output logic            pop,
  output logic [SP_W-1:0] sp,
  output logic            stack_err,
  output logic            halted
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q;

  logic            is_ctrl, is_jsb, is_ret, taken, stack_fault;
  logic [1:0]      op, cond;
  logic [PC_W-1:0] pc_inc, br_off, target, next_pc, stk_rdata;
  logic            stk_full, stk_empty, pc_load, err_set;

  assign is_ctrl = (instruction[18:16] == CTRL_CLASS);
  assign op      = instruction[15:14];
  assign cond    = instruction[13:12];
  assign target  = instruction[PC_W-1:0];
  assign br_off  = {{(PC_W-8){instruction[7]}}, instruction[7:0]};
  assign pc_inc  = pc_q + PC_W'(1);
  assign is_jsb  = is_ctrl && (op == OP_JSB);
  assign is_ret  = is_ctrl && (op == OP_RET);

  assign stack_fault = (is_jsb && stk_full) || (is_ret && stk_empty);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_Z:  taken = z_flag;
      COND_NZ: taken = !z_flag;
      COND_C:  taken = c_flag;
      COND_NC: taken = !c_flag;
    endcase
  end

  always_comb begin
    next_pc = pc_inc;
    if (is_ctrl) begin
      case (op)
        OP_BR:  next_pc = taken ? (pc_inc + br_off) : pc_inc;
        OP_JMP: next_pc = target;
        OP_JSB: next_pc = target;
        OP_RET: next_pc = stk_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && pc_en && stack_fault) begin
      state_d = HALT;
    end
  end

  // Strobes are gated by rst so nothing looks accepted while reset is held.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    pc_load = 1'b0;
    err_set = 1'b0;
    if (!rst && state_q == RUN && pc_en) begin
      if (stack_fault) begin
        err_set = 1'b1;
      end else begin
        pc_load = 1'b1;
        push    = is_jsb;
        pop     = is_ret;
      end
    end
  end

  assign pc_d = pc_load ? next_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_q | err_set;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .rdata (stk_rdata),
    .sp    (sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign pc        = pc_q;
  assign stack_err = err_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int PC_W  = 12;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [18:0]     instruction;
  logic            pc_en, c_flag, z_flag;
  logic [PC_W-1:0] pc;
  logic            push, pop;
  logic [3:0]      sp;
  logic            stack_err, halted;

  int vectors     = 0;
  int miscompares = 0;

  int         m_pc, n_pc;
  int         stk[$];
  bit         m_halt, m_err, e_push, e_pop, tk, en;
  logic [18:0] ins;
  logic signed [7:0] o8;

  localparam logic [18:0] NOP = 19'h00000;

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc_en       (pc_en),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .pc          (pc),
    .push        (push),
    .pop         (pop),
    .sp          (sp),
    .stack_err   (stack_err),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [1:0] op, input logic [1:0] cond, input logic [11:0] low);
    return {CTRL_CLASS, op, cond, low};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [18:0] i, input logic e, input logic c, input logic z);
    instruction = i;
    pc_en       = e;
    c_flag      = c;
    z_flag      = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a JSB presented: nothing may be accepted.
    rst = 1'b1;
    drive(mk(OP_JSB, 2'b00, 12'h100), 1'b1, 1'b0, 1'b0);
    check("rst_push", push, 0);
    check("rst_pop", pop, 0);
    tick();
    check("rst_pc", pc, 0);
    check("rst_sp", sp, 0);
    check("rst_err", stack_err, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      drive(NOP, 1'b1, 1'b0, 1'b0);
      tick();
      check("seq_pc", pc, i);
    end
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 0);
    rst = 1'b0;

    drive(mk(OP_JMP, 2'b00, 12'h010), 1'b1, 1'b0, 1'b0); tick();
    check("jmp_pc", pc, 12'h010);
    drive(mk(OP_BR, COND_Z, 12'h0FB), 1'b1, 1'b0, 1'b1); tick();
    check("bz_taken_pc", pc, 12'h00C);
    drive(mk(OP_JMP, 2'b00, 12'h010), 1'b1, 1'b0, 1'b0); tick();
    drive(mk(OP_BR, COND_Z, 12'h0FB), 1'b1, 1'b0, 1'b0); tick();
    check("bz_untaken_pc", pc, 12'h011);
    drive(mk(OP_BR, COND_NC, 12'h005), 1'b1, 1'b0, 1'b0); tick();
    check("bnc_taken_pc", pc, 12'h017);
    drive(mk(OP_BR, COND_NC, 12'h005), 1'b1, 1'b1, 1'b0); tick();
    check("bnc_untaken_pc", pc, 12'h018);

    drive(mk(OP_JMP, 2'b00, 12'h020), 1'b1, 1'b0, 1'b0); tick();
    drive(mk(OP_JSB, 2'b00, 12'h100), 1'b1, 1'b0, 1'b0);
    check("jsb_push", push, 1);
    check("jsb_pop", pop, 0);
    tick();
    check("jsb_pc", pc, 12'h100);
    check("jsb_sp", sp, 1);
    drive(mk(OP_RET, 2'b00, 12'h000), 1'b1, 1'b0, 1'b0);
    check("ret_pop", pop, 1);
    tick();
    check("ret_pc", pc, 12'h021);
    check("ret_sp", sp, 0);

    for (int i = 0; i < DEPTH; i++) begin
      drive(mk(OP_JSB, 2'b00, 12'h300), 1'b1, 1'b0, 1'b0);
      check("nest_push", push, 1);
      tick();
      check("nest_pc", pc, 12'h300);
      check("nest_sp", sp, i + 1);
    end
    check("nest_err", stack_err, 0);
    drive(mk(OP_RET, 2'b00, 12'h000), 1'b1, 1'b0, 1'b0); tick();
    check("full_ret_pc", pc, 12'h301);
    check("full_ret_sp", sp, 7);
    drive(mk(OP_JSB, 2'b00, 12'h300), 1'b1, 1'b0, 1'b0); tick();
    check("refill_sp", sp, 8);
    drive(mk(OP_JSB, 2'b00, 12'h200), 1'b1, 1'b0, 1'b0);
    check("ovf_push", push, 0);
    tick();
    check("ovf_pc", pc, 12'h300);
    check("ovf_sp", sp, 8);
    check("ovf_err", stack_err, 1);
    check("ovf_halted", halted, 1);
    drive(mk(OP_JMP, 2'b00, 12'h123), 1'b1, 1'b0, 1'b0);
    check("halt_push", push, 0);
    tick();
    check("halt_pc", pc, 12'h300);
    drive(mk(OP_RET, 2'b00, 12'h000), 1'b1, 1'b0, 1'b0);
    check("halt_pop", pop, 0);
    tick();
    check("halt_sp", sp, 8);
    check("halt_still", halted, 1);

    rst = 1'b1;
    #1;
    check("halt_rst_pc", pc, 0);
    check("halt_rst_err", stack_err, 0);
    check("halt_rst_halted", halted, 0);
    check("halt_rst_sp", sp, 0);
    rst = 1'b0;

    drive(mk(OP_RET, 2'b00, 12'h000), 1'b1, 1'b0, 1'b0);
    check("udf_pop", pop, 0);
    tick();
    check("udf_pc", pc, 0);
    check("udf_err", stack_err, 1);
    check("udf_halted", halted, 1);
    rst = 1'b1;
    #1;
    rst = 1'b0;

    drive(mk(OP_JMP, 2'b00, 12'hFFF), 1'b1, 1'b0, 1'b0); tick();
    check("pre_wrap_pc", pc, 12'hFFF);
    drive(NOP, 1'b1, 1'b0, 1'b0); tick();
    check("wrap_pc", pc, 0);
    drive(mk(OP_JSB, 2'b00, 12'h100), 1'b0, 1'b0, 1'b0);
    check("dis_push", push, 0);
    tick();
    check("dis_pc", pc, 0);
    check("dis_sp", sp, 0);

    // Randomized phase against a queue-based reference model.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_pc = 0; stk.delete(); m_halt = 0; m_err = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_halt) begin
        rst = 1'b1;
        #1;
        check("rnd_rst_pc", pc, 0);
        rst = 1'b0;
        m_pc = 0; stk.delete(); m_halt = 0; m_err = 0;
        continue;
      end
      ins = 19'($urandom);
      if ($urandom_range(0, 3) >= 2) ins[18:16] = 3'b111;
      en = ($urandom_range(0, 9) != 0);
      drive(ins, en, 1'($urandom), 1'($urandom));
      e_push = 0; e_pop = 0; n_pc = m_pc;
      if (en) begin
        if (ins[18:16] != 3'b111) begin
          n_pc = (m_pc + 1) & 4095;
        end else begin
          case (ins[15:14])
            2'd0: begin
              case (ins[13:12])
                2'd0: tk = z_flag;
                2'd1: tk = !z_flag;
                2'd2: tk = c_flag;
                default: tk = !c_flag;
              endcase
              o8 = ins[7:0];
              n_pc = tk ? ((m_pc + 1 + int'(o8)) & 4095) : ((m_pc + 1) & 4095);
            end
            2'd1: n_pc = ins[11:0];
            2'd2: begin
              if (stk.size() == DEPTH) begin
                m_halt = 1; m_err = 1;
              end else begin
                stk.push_back((m_pc + 1) & 4095);
                n_pc = ins[11:0];
                e_push = 1;
              end
            end
            default: begin
              if (stk.size() == 0) begin
                m_halt = 1; m_err = 1;
              end else begin
                n_pc = stk.pop_back();
                e_pop = 1;
              end
            end
          endcase
        end
      end
      check("rnd_push", push, e_push);
      check("rnd_pop", pop, e_pop);
      tick();
      m_pc = n_pc;
      check("rnd_pc", pc, m_pc);
      check("rnd_sp", sp, stk.size());
      check("rnd_err", stack_err, m_err);
      check("rnd_halted", halted, m_halt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
